stoch_to_bin_decoder: RTL and testbench

- Reader end of the stochastic datapath. Consumes a serial stochastic bitstream, such as the output of the scaling subtracter or multiplier, and converts it to a binary value.
- Counts the ones in a fixed window of N = 2**WIDTH valid bits and presents the count through a valid/ready output register.
- Sits at the boundary between the stochastic operator chain and binary logic such as a register file or a result checker.

---
 rtl/stoch_pkg.sv | 24 ++
 rtl/stoch_ones_counter.sv | 47 ++++
 rtl/stoch_to_bin_decoder.sv | 125 ++++++++++++
 tb/tb_stoch_to_bin_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoder.
// The optional bipolar output of the decoder is enabled with STOCH_BIPOLAR_EN.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } dec_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Window length N = 2**width.
    function automatic int unsigned win_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic logic [31:0] sat_unsigned(input int unsigned width, input logic [31:0] value);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Window position and ones counters for one conversion window of 2**WIDTH valid bits.
// Clear takes priority over counting; last_o flags that the next valid bit is the Nth.
module stoch_ones_counter
    import stoch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic           bit_i,
    output logic [WIDTH:0] ones_cnt_o,
    output logic           last_o
);

    localparam logic [WIDTH:0] LAST_IDX = (WIDTH+1)'(win_len(WIDTH) - 1);

    logic [WIDTH:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH:0] ones_cnt_q, ones_cnt_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (clr_i) begin
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
        end else if (en_i) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            ones_cnt_d = ones_cnt_q + (WIDTH+1)'(bit_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign ones_cnt_o = ones_cnt_q;
    assign last_o     = (bit_cnt_q == LAST_IDX);

endmodule

// File: rtl/stoch_to_bin_decoder.sv
// Converts a serial stochastic bitstream to a binary ones count over a 2**WIDTH-bit window.
// Define STOCH_BIPOLAR_EN to add the signed out_bipolar = 2*ones - N output.
module stoch_to_bin_decoder
    import stoch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state
`ifdef STOCH_BIPOLAR_EN
    ,
    output logic signed [WIDTH+1:0] out_bipolar
`endif
);

    // Output handshake: out_data is valid while out_valid=1 and is consumed on
    // any rising edge where out_valid=1 and out_ready=1; it is held until then.

    dec_state_t       state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             cnt_clr, cnt_en, cnt_last, load;
    logic [WIDTH:0]   ones_cnt;
    logic [WIDTH:0]   final_ones;

    stoch_ones_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .bit_i      (bit_in),
        .ones_cnt_o (ones_cnt),
        .last_o     (cnt_last)
    );

    // The Nth bit is still in flight, so the final count includes it directly.
    assign final_ones = ones_cnt + (WIDTH+1)'(bit_in);

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        load       = 1'b0;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    cnt_clr = 1'b1;
                end else if (bit_valid) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = HOLD;
                        load    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_data_d = WIDTH'(sat_unsigned(WIDTH, 32'(final_ones)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef STOCH_BIPOLAR_EN
    logic signed [WIDTH+1:0] bipolar_q, bipolar_d;

    always_comb begin
        bipolar_d = bipolar_q;
        if (load) begin
            bipolar_d = $signed({final_ones, 1'b0}) - $signed((WIDTH+2)'(win_len(WIDTH)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bipolar_q <= '0;
        end else begin
            bipolar_q <= bipolar_d;
        end
    end

    assign out_bipolar = bipolar_q;
`endif

    assign busy      = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stoch_to_bin_decoder.sv
// Directed bench for stoch_to_bin_decoder at WIDTH=4 (N=16) with a queue-based scoreboard.
// Expected results are pushed at window start; a monitor pops them on each output transfer.
module tb_stoch_to_bin_decoder;

    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic         out_ready;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   dbg_state;
`ifdef STOCH_BIPOLAR_EN
    logic signed [W+1:0] out_bipolar;
    logic [W+1:0]        bip_raw;
    assign bip_raw = out_bipolar;
`endif

    int total = 0;
    int bad   = 0;
    logic [2*W+1:0] exp_q[$];
    logic [2*W+1:0] exp_e;

    stoch_to_bin_decoder #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
`ifdef STOCH_BIPOLAR_EN
        ,
        .out_bipolar (out_bipolar)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected unipolar (saturated) and bipolar (unsaturated) results for a given ones count.
    task automatic push_exp(input int ones);
        logic [W-1:0] d;
        logic [W+1:0] b;
        d = W'((ones > N - 1) ? N - 1 : ones);
        b = (W+2)'(2 * ones - N);
        exp_q.push_back({d, b});
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic end_window(input string name);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check(name, out_valid, 1);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("out_data", out_data, exp_e[2*W+1:W+2]);
`ifdef STOCH_BIPOLAR_EN
                check("out_bipolar", bip_raw, exp_e[W+1:0]);
`endif
            end
        end
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // All-ones window saturates
        pulse_start();
        check("t1_busy", busy, 1);
        push_exp(16);
        for (int i = 0; i < N; i++) begin
            send(1'b1, 1'b1);
            if (i == N - 2) check("t1_latency_early", out_valid, 0);
        end
        end_window("t1_out_valid");
        check("t1_busy_in_hold", busy, 0);
        step();
        check("t1_valid_drop", out_valid, 0);

        // Alternating ones and zeros
        pulse_start();
        push_exp(8);
        for (int i = 0; i < N; i++) send(1'((i % 2) == 0), 1'b1);
        end_window("t2_out_valid");
        step();
        check("t2_busy_after", busy, 0);
        check("t2_valid_drop", out_valid, 0);

        // Zeros with bit_valid toggling: 32 cycles for 16 valid bits
        pulse_start();
        push_exp(0);
        for (int i = 0; i < 2 * N; i++) begin
            send(1'b0, 1'((i % 2) == 1));
            if (i == 2 * N - 2) check("t3_latency_early", out_valid, 0);
        end
        end_window("t3_out_valid");
        step();

        // Back-pressure: output held, start ignored, then start with ready restarts
        out_ready = 1'b0;
        pulse_start();
        push_exp(5);
        for (int i = 0; i < N; i++) send(1'(i < 5), 1'b1);
        end_window("t4_out_valid");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            step();
            start = 1'b0;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 5);
            check("t4_hold_busy", busy, 0);
        end
        push_exp(3);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_busy", busy, 1);
        for (int i = 0; i < N; i++) send(1'(i < 3), 1'b1);
        end_window("t4_second_valid");
        step();

        // start mid-window aborts; the bit sampled with start is discarded
        pulse_start();
        push_exp(4);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
        start     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        step();
        start = 1'b0;
        check("t5_busy_restart", busy, 1);
        for (int i = 0; i < N; i++) send(1'((i % 4) == 0), 1'b1);
        end_window("t5_out_valid");
        step();

        // Asynchronous reset mid-window, between clock edges
        pulse_start();
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        rst       = 1'b0;
        bit_valid = 1'b0;
        step();
        check("t6_idle_after_rst", busy, 0);
        pulse_start();
        push_exp(10);
        for (int i = 0; i < N; i++) send(1'(i < 10), 1'b1);
        end_window("t6_out_valid");
        step();

        step();
        step();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
